// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared state encoding and constants for the async SRAM controller
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  localparam int   CNT_WIDTH         = 4;
  localparam logic LAST_WAS_READ_RST = 1'b1;

endpackage

// File: rtl/sram_ctrl_arb.sv
// rtl/sram_ctrl_arb.sv - two-port round-robin grant for the SRAM controller
module sram_ctrl_arb (
  input  logic wr_req,
  input  logic rd_req,
  input  logic idle,
  input  logic last_was_read,
  output logic wr_ack,
  output logic rd_ack
);

  // On a tie the port that was not served last wins.
  assign wr_ack = idle && wr_req && (!rd_req || last_was_read);
  assign rd_ack = idle && rd_req && (!wr_req || !last_was_read);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - single-word read/write handshakes to async SRAM strobe sequences
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 18,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  sram_ceb,
  output logic                  sram_web,
  output logic                  sram_oeb,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = WAIT_CYCLES[CNT_WIDTH-1:0];

  state_t                 state, state_nxt;
  logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
  logic                   op_rd, rd_nxt;
  logic                   last_was_read;
  logic [DATA_WIDTH-1:0]  wdata;
  logic                   drive;
  logic                   idle, accept, capture;
  logic                   ceb_nxt, web_nxt, oeb_nxt, drive_nxt;
  logic [ADDR_WIDTH-1:0]  addr_nxt;

  assign idle   = (state == ST_IDLE) && resetb;
  assign accept = wr_ack || rd_ack;

  sram_ctrl_arb u_arb (
    .wr_req        (wr_req),
    .rd_req        (rd_req),
    .idle          (idle),
    .last_was_read (last_was_read),
    .wr_ack        (wr_ack),
    .rd_ack        (rd_ack)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rd_nxt    = op_rd;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_SETUP;
          rd_nxt    = rd_ack;
        end
      end
      ST_SETUP: begin
        state_nxt = ST_STROBE;
        cnt_nxt   = '0;
      end
      ST_STROBE: begin
        if (cnt == WAIT_LAST) state_nxt = ST_HOLD;
        else                  cnt_nxt   = cnt + 1'b1;
      end
      ST_HOLD: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Pin values are decoded from the next state so every SRAM pin leaves a flop.
  always_comb begin
    ceb_nxt   = 1'b1;
    web_nxt   = 1'b1;
    oeb_nxt   = 1'b1;
    drive_nxt = 1'b0;
    addr_nxt  = sram_addr;
    case (state_nxt)
      ST_SETUP: begin
        ceb_nxt   = 1'b0;
        oeb_nxt   = !rd_nxt;
        drive_nxt = !rd_nxt;
        addr_nxt  = rd_ack ? rd_addr : wr_addr;
      end
      ST_STROBE: begin
        ceb_nxt   = 1'b0;
        web_nxt   = rd_nxt;
        oeb_nxt   = !rd_nxt;
        drive_nxt = !rd_nxt;
      end
      ST_HOLD: begin
        ceb_nxt   = 1'b0;
        drive_nxt = !rd_nxt;
      end
      default: ;
    endcase
  end

  assign capture = (state == ST_STROBE) && (state_nxt == ST_HOLD) && op_rd;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      sram_ceb      <= 1'b1;
      sram_web      <= 1'b1;
      sram_oeb      <= 1'b1;
      sram_addr     <= '0;
      drive         <= 1'b0;
      op_rd         <= 1'b0;
      wdata         <= '0;
      last_was_read <= LAST_WAS_READ_RST;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
    end else begin
      sram_ceb  <= ceb_nxt;
      sram_web  <= web_nxt;
      sram_oeb  <= oeb_nxt;
      sram_addr <= addr_nxt;
      drive     <= drive_nxt;
      op_rd     <= rd_nxt;
      rd_valid  <= capture;
      if (wr_ack)  wdata         <= wr_data;
      if (accept)  last_was_read <= rd_ack;
      if (capture) rd_data       <= sram_data;
    end
  end

  assign sram_data = drive ? wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed bench for sram_ctrl at WAIT_CYCLES 1, 0 and 3
module tb_sram_ctrl;

  logic             clk;
  logic [2:0]       resetb;
  logic [2:0]       wr_req, rd_req;
  logic [2:0][17:0] wr_addr, rd_addr;
  logic [2:0][15:0] wr_data;
  wire  [2:0]       wr_ack, rd_ack, rd_valid, ceb, web, oeb;
  wire  [2:0][17:0] sram_addr;
  wire  [2:0][15:0] rd_data, bus_obs;
  wire  [2:0][31:0] mon_cnt;

  int vectors = 0;
  int errs    = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wc(input int idx);
    return (idx == 0) ? 1 : ((idx == 1) ? 0 : 3);
  endfunction

  // Instance 0: WAIT_CYCLES=1, instance 1: 0, instance 2: 3; each with its own SRAM model.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    wire  [15:0] bus;
    logic [15:0] mem [256];
    logic        mdl_drv = 1'b0;
    logic        prev_ceb = 1'b1;
    logic [17:0] prev_addr = '0;
    int          mon = 0;

    pullup pu_bus (bus);

    sram_ctrl #(.ADDR_WIDTH(18), .DATA_WIDTH(16), .WAIT_CYCLES(W)) u_dut (
      .clk       (clk),
      .resetb    (resetb[g]),
      .wr_req    (wr_req[g]),
      .wr_addr   (wr_addr[g]),
      .wr_data   (wr_data[g]),
      .wr_ack    (wr_ack[g]),
      .rd_req    (rd_req[g]),
      .rd_addr   (rd_addr[g]),
      .rd_ack    (rd_ack[g]),
      .rd_data   (rd_data[g]),
      .rd_valid  (rd_valid[g]),
      .sram_ceb  (ceb[g]),
      .sram_web  (web[g]),
      .sram_oeb  (oeb[g]),
      .sram_addr (sram_addr[g]),
      .sram_data (bus)
    );

    // The model starts driving one clock after oeb falls, so a DUT drive in SETUP shows up.
    always @(posedge clk) begin
      mdl_drv <= !oeb[g] && !ceb[g];
      if (!ceb[g] && !web[g]) mem[sram_addr[g][7:0]] <= bus;
    end

    assign bus = (mdl_drv && !oeb[g] && !ceb[g]) ? mem[sram_addr[g][7:0]] : 16'bz;
    assign bus_obs[g] = bus;
    assign mon_cnt[g] = mon;

    always @(negedge clk) begin
      if (!oeb[g] && !mdl_drv && bus !== 16'hFFFF) mon = mon + 1;
      if (!ceb[g] && !prev_ceb && sram_addr[g] !== prev_addr) mon = mon + 1;
      prev_ceb  = ceb[g];
      prev_addr = sram_addr[g];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic access(input int idx, input bit rd, input logic [17:0] addr,
                        input logic [15:0] data, output int web_lo, output int oe_lo,
                        output int ceb_lo, output int drv_cyc, output int vlat, output int vcnt);
    int n;
    int w;
    w = wc(idx);
    web_lo = 0; oe_lo = 0; ceb_lo = 0; drv_cyc = 0; vlat = -1; vcnt = 0;
    @(negedge clk);
    if (rd) begin
      rd_req[idx]  = 1'b1;
      rd_addr[idx] = addr;
    end else begin
      wr_req[idx]  = 1'b1;
      wr_addr[idx] = addr;
      wr_data[idx] = data;
    end
    #1;
    n = 0;
    while (!(rd ? rd_ack[idx] : wr_ack[idx]) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("ack_timeout", 32'(n < 20), 32'd1);
    @(posedge clk);
    #1;
    rd_req[idx] = 1'b0;
    wr_req[idx] = 1'b0;
    for (int k = 1; k <= w + 5; k++) begin
      @(negedge clk);
      if (!web[idx]) web_lo++;
      if (!oeb[idx]) oe_lo++;
      if (!ceb[idx]) ceb_lo++;
      if (!rd && bus_obs[idx] === data) drv_cyc++;
      if (rd_valid[idx]) begin
        vcnt++;
        vlat = k;
      end
    end
  endtask

  int web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt;
  int gt [8];
  int gc [8];
  int ng, both, bad;

  initial begin
    resetb  = '0;
    wr_req  = '0;
    rd_req  = '0;
    wr_addr = '0;
    rd_addr = '0;
    wr_data = '0;
    ng = 0; both = 0; bad = 0;

    // Reset state, with both requests already high on instance 0.
    wr_req[0] = 1'b1;  wr_addr[0] = 18'h00020;  wr_data[0] = 16'h5A5A;
    rd_req[0] = 1'b1;  rd_addr[0] = 18'h00021;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ceb",    32'(ceb[0]),      32'd1);
    chk("rst_web",    32'(web[0]),      32'd1);
    chk("rst_oeb",    32'(oeb[0]),      32'd1);
    chk("rst_addr",   32'(sram_addr[0]), 32'd0);
    chk("rst_valid",  32'(rd_valid[0]), 32'd0);
    chk("rst_rdata",  32'(rd_data[0]),  32'd0);
    chk("rst_wr_ack", 32'(wr_ack[0]),   32'd0);
    chk("rst_rd_ack", 32'(rd_ack[0]),   32'd0);
    chk("rst_bus_z",  32'(bus_obs[0]),  32'hFFFF);

    // Requests held continuously from reset: W,R,W,R every 5 cycles.
    resetb = '1;
    #1;
    for (int c = 0; c < 22; c++) begin
      if (wr_ack[0] && rd_ack[0]) both++;
      if (ng < 8 && wr_ack[0]) begin gt[ng] = 0; gc[ng] = c; ng++; end
      else if (ng < 8 && rd_ack[0]) begin gt[ng] = 1; gc[ng] = c; ng++; end
      @(negedge clk);
      #1;
    end
    wr_req[0] = 1'b0;
    rd_req[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("rr_count", 32'(ng >= 4), 32'd1);
    chk("rr_both",  32'(both), 32'd0);
    chk("rr_g0", 32'(gt[0]), 32'd0);
    chk("rr_g1", 32'(gt[1]), 32'd1);
    chk("rr_g2", 32'(gt[2]), 32'd0);
    chk("rr_g3", 32'(gt[3]), 32'd1);
    chk("rr_gap1", 32'(gc[1] - gc[0]), 32'd5);
    chk("rr_gap2", 32'(gc[2] - gc[1]), 32'd5);
    chk("rr_gap3", 32'(gc[3] - gc[2]), 32'd5);

    // WAIT_CYCLES=1 write and read-back.
    access(0, 1'b0, 18'h00012, 16'hBEEF, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("w1_web_width", 32'(web_lo),  32'd2);
    chk("w1_ceb_width", 32'(ceb_lo),  32'd4);
    chk("w1_bus_drive", 32'(drv_cyc), 32'd4);
    chk("w1_oe_low",    32'(oe_lo),   32'd0);
    chk("w1_no_valid",  32'(vcnt),    32'd0);
    chk("w1_mem",       32'(g_dut[0].mem[8'h12]), 32'hBEEF);
    access(0, 1'b1, 18'h00012, 16'h0000, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("r1_latency",  32'(vlat),       32'd4);
    chk("r1_pulses",   32'(vcnt),       32'd1);
    chk("r1_data",     32'(rd_data[0]), 32'hBEEF);
    chk("r1_oe_width", 32'(oe_lo),      32'd3);
    chk("r1_web",      32'(web_lo),     32'd0);
    repeat (5) @(negedge clk);
    chk("r1_hold",     32'(rd_data[0]), 32'hBEEF);

    access(0, 1'b0, 18'h3FF45, 16'h1234, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("w1b_web_width", 32'(web_lo), 32'd2);
    access(0, 1'b1, 18'h3FF45, 16'h0000, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("r1b_data", 32'(rd_data[0]), 32'h1234);

    // WAIT_CYCLES=0.
    access(1, 1'b0, 18'h00005, 16'h0F0F, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("w0_web_width", 32'(web_lo),  32'd1);
    chk("w0_bus_drive", 32'(drv_cyc), 32'd3);
    access(1, 1'b1, 18'h00005, 16'h0000, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("r0_latency", 32'(vlat),       32'd3);
    chk("r0_data",    32'(rd_data[1]), 32'h0F0F);

    // WAIT_CYCLES=3.
    access(2, 1'b0, 18'h00006, 16'hC3C3, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("w3_web_width", 32'(web_lo),  32'd4);
    chk("w3_bus_drive", 32'(drv_cyc), 32'd6);
    access(2, 1'b1, 18'h00006, 16'h0000, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("r3_latency", 32'(vlat),       32'd6);
    chk("r3_data",    32'(rd_data[2]), 32'hC3C3);

    // Asynchronous reset in the middle of a write strobe.
    @(negedge clk);
    wr_req[0] = 1'b1;  wr_addr[0] = 18'h00030;  wr_data[0] = 16'h7777;
    #1;
    chk("mid_ack", 32'(wr_ack[0]), 32'd1);
    @(posedge clk);
    #1;
    wr_req[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_strobe_web", 32'(web[0]), 32'd0);
    #2;
    resetb[0] = 1'b0;
    #1;
    chk("mid_rst_ceb", 32'(ceb[0]),     32'd1);
    chk("mid_rst_web", 32'(web[0]),     32'd1);
    chk("mid_rst_oeb", 32'(oeb[0]),     32'd1);
    chk("mid_rst_bus", 32'(bus_obs[0]), 32'hFFFF);
    @(negedge clk);
    resetb[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wr_ack[0] || rd_ack[0] || !ceb[0]) bad++;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);
    access(0, 1'b0, 18'h00030, 16'h7777, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("post_rst_web_width", 32'(web_lo), 32'd2);
    access(0, 1'b1, 18'h00030, 16'h0000, web_lo, oe_lo, ceb_lo, drv_cyc, vlat, vcnt);
    chk("post_rst_rdata", 32'(rd_data[0]), 32'h7777);

    chk("bus_monitor_w1", mon_cnt[0], 32'd0);
    chk("bus_monitor_w0", mon_cnt[1], 32'd0);
    chk("bus_monitor_w3", mon_cnt[2], 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
